// File: rtl/and32_result_stage.sv
// Registered result stage behind the 32-bit AND unit: 2-entry FIFO with valid/ready on both sides,
// per-entry zero/negative flags and a wrapping count of delivered results.
module and32_result_stage #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             out_neg,
    output logic [CNT_W-1:0] done_cnt
);

    function automatic logic zero_flag(input logic [WIDTH-1:0] d);
        return ~|d;
    endfunction

    function automatic logic neg_flag(input logic [WIDTH-1:0] d);
        return d[WIDTH-1];
    endfunction

    logic [WIDTH-1:0] mem_data_r [2];
    logic             mem_zero_r [2];
    logic             mem_neg_r  [2];
    logic             wr_ptr_r;
    logic             rd_ptr_r;
    logic [1:0]       count_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] out_data_r;
    logic             out_zero_r;
    logic             out_neg_r;
    logic [CNT_W-1:0] done_cnt_r;

    logic             push_s;
    logic             pop_s;
    logic [1:0]       count_nxt_s;
    logic             rd_nxt_s;
    logic             wr_nxt_s;
    logic [WIDTH-1:0] head_data_s;
    logic             head_zero_s;
    logic             head_neg_s;

    // Full blocks a push regardless of a same-cycle pop, so in_ready depends on state only.
    assign in_ready  = rst_n & (count_r != 2'd2);
    assign push_s    = in_valid & in_ready;
    assign pop_s     = out_valid_r & out_ready;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_zero  = out_zero_r;
    assign out_neg   = out_neg_r;
    assign done_cnt  = done_cnt_r;

    // Next occupancy and pointer values.
    always_comb begin
        count_nxt_s = count_r;
        rd_nxt_s    = rd_ptr_r;
        wr_nxt_s    = wr_ptr_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + 2'd1;
            2'b01:   count_nxt_s = count_r - 2'd1;
            default: count_nxt_s = count_r;
        endcase
        if (pop_s) begin
            rd_nxt_s = ~rd_ptr_r;
        end else begin
            rd_nxt_s = rd_ptr_r;
        end
        if (push_s) begin
            wr_nxt_s = ~wr_ptr_r;
        end else begin
            wr_nxt_s = wr_ptr_r;
        end
    end

    // Next head entry: bypass the incoming result when it lands in the slot that becomes the head.
    always_comb begin
        head_data_s = mem_data_r[rd_nxt_s];
        head_zero_s = mem_zero_r[rd_nxt_s];
        head_neg_s  = mem_neg_r[rd_nxt_s];
        if (push_s && (rd_nxt_s == wr_ptr_r)) begin
            head_data_s = in_data;
            head_zero_s = zero_flag(in_data);
            head_neg_s  = neg_flag(in_data);
        end else begin
            head_data_s = mem_data_r[rd_nxt_s];
            head_zero_s = mem_zero_r[rd_nxt_s];
            head_neg_s  = mem_neg_r[rd_nxt_s];
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r  <= 2'd0;
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
        end else begin
            count_r  <= count_nxt_s;
            rd_ptr_r <= rd_nxt_s;
            wr_ptr_r <= wr_nxt_s;
        end
    end

    // Entry storage: data with flags captured at push time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_data_r[0] <= {WIDTH{1'b0}};
            mem_data_r[1] <= {WIDTH{1'b0}};
            mem_zero_r[0] <= 1'b0;
            mem_zero_r[1] <= 1'b0;
            mem_neg_r[0]  <= 1'b0;
            mem_neg_r[1]  <= 1'b0;
        end else if (push_s) begin
            mem_data_r[wr_ptr_r] <= in_data;
            mem_zero_r[wr_ptr_r] <= zero_flag(in_data);
            mem_neg_r[wr_ptr_r]  <= neg_flag(in_data);
        end
    end

    // Registered head outputs; they hold their last value once the FIFO drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {WIDTH{1'b0}};
            out_zero_r  <= 1'b0;
            out_neg_r   <= 1'b0;
        end else begin
            out_valid_r <= (count_nxt_s != 2'd0);
            if (count_nxt_s != 2'd0) begin
                out_data_r <= head_data_s;
                out_zero_r <= head_zero_s;
                out_neg_r  <= head_neg_s;
            end
        end
    end

    // Delivered-result counter, wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_cnt_r <= {CNT_W{1'b0}};
        end else if (pop_s) begin
            done_cnt_r <= done_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_and32_result_stage.sv
// Scoreboard bench for and32_result_stage: accepted inputs are queued with their expected flags,
// a monitor pops and compares on every delivered result; directed tests check the handshake corners.
module tb_and32_result_stage;

    localparam int WIDTH = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = 32'h0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic             out_zero;
    logic             out_neg;
    logic [CNT_W-1:0] done_cnt;

    int errors = 0;
    int checks = 0;
    logic [33:0] sb_q[$];
    logic [CNT_W-1:0] exp_done = 4'd0;
    int stream_valid;

    and32_result_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_zero(out_zero), .out_neg(out_neg), .done_cnt(done_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Recorder: an accepted input becomes an expected output.
    initial forever begin
        @(negedge clk);
        if (rst_n && in_valid && in_ready)
            sb_q.push_back({(in_data == 32'h0), in_data[31], in_data});
    end

    // Monitor: compare every delivered result and the running pop count.
    initial forever begin
        logic [33:0] e;
        @(negedge clk);
        if (!rst_n) begin
            sb_q.delete();
            exp_done = 4'd0;
        end else begin
            check("done_cnt", 32'(done_cnt), 32'(exp_done));
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_output", out_data, 32'hDEAD_BEEF);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_data", out_data, e[31:0]);
                    check("sb_zero", 32'(out_zero), 32'(e[33]));
                    check("sb_neg", 32'(out_neg), 32'(e[32]));
                end
                exp_done = exp_done + 4'd1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] d);
        int waited;
        in_valid = 1'b1;
        in_data  = d;
        waited   = 0;
        @(negedge clk);
        while (!in_ready && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) check("push_timeout", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset, then idle
        #1 check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        idle(5);
        @(negedge clk);
        check("idle_out_valid", 32'(out_valid), 32'd0);
        check("idle_in_ready", 32'(in_ready), 32'd1);
        check("idle_done_cnt", 32'(done_cnt), 32'd0);
        check("idle_out_data", out_data, 32'h0);
        check("idle_flags", {30'd0, out_zero, out_neg}, 32'd0);

        // Single pass
        tick();
        out_ready = 1'b1;
        push_one(32'hF0F0_0000);
        @(negedge clk);
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_data", out_data, 32'hF0F0_0000);
        check("single_neg", 32'(out_neg), 32'd1);
        check("single_zero", 32'(out_zero), 32'd0);
        @(negedge clk);
        check("single_valid_after", 32'(out_valid), 32'd0);
        check("single_done", 32'(done_cnt), 32'd1);
        check("single_hold", out_data, 32'hF0F0_0000);

        // Backpressure
        tick();
        out_ready = 1'b0;
        push_one(32'h0);
        push_one(32'h1);
        @(negedge clk);
        check("bp_full_ready", 32'(in_ready), 32'd0);
        check("bp_head_data", out_data, 32'h0);
        check("bp_head_zero", 32'(out_zero), 32'd1);
        tick();
        in_valid = 1'b1;
        in_data  = 32'h0000_0002;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_blocked", 32'(in_ready), 32'd0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle(3);
        @(negedge clk);
        check("bp_drained", 32'(out_valid), 32'd0);
        check("bp_done", 32'(done_cnt), 32'd3);

        // Streaming: crosses 0xFFFFFFFF -> 0 at i=64
        tick();
        stream_valid = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_data = 32'hFFFF_FFC0 + 32'(i);
            @(negedge clk);
            check("stream_ready", 32'(in_ready), 32'd1);
            if (out_valid) stream_valid++;
            tick();
        end
        in_valid = 1'b0;
        idle(3);
        @(negedge clk);
        check("stream_valid_cycles", 32'(stream_valid), 32'd99);
        check("stream_done", 32'(done_cnt), 32'd7);
        check("stream_sb_empty", 32'(sb_q.size()), 32'd0);

        // Simultaneous push/pop at count==1
        tick();
        out_ready = 1'b0;
        push_one(32'hA5A5_A5A5);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h5A5A_5A5A;
        @(negedge clk);
        check("pp_head_a", out_data, 32'hA5A5_A5A5);
        check("pp_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        check("pp_head_b", out_data, 32'h5A5A_5A5A);
        check("pp_count1_ready", 32'(in_ready), 32'd1);
        check("pp_count1_valid", 32'(out_valid), 32'd1);
        tick();
        out_ready = 1'b1;
        idle(2);
        @(negedge clk);
        check("pp_done", 32'(done_cnt), 32'd9);

        // Reset while full
        tick();
        out_ready = 1'b0;
        push_one(32'h1111_1111);
        push_one(32'h2222_2222);
        @(negedge clk);
        check("mid_full", 32'(in_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1 check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd0);
        check("mid_rst_data", out_data, 32'h0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_valid", 32'(out_valid), 32'd0);
        check("post_rst_ready", 32'(in_ready), 32'd1);
        check("post_rst_done", 32'(done_cnt), 32'd0);
        tick();
        out_ready = 1'b1;
        idle(4);
        @(negedge clk);
        check("post_rst_no_old", 32'(out_valid), 32'd0);

        // done_cnt wrap with CNT_W=4
        tick();
        in_valid = 1'b1;
        for (int i = 0; i < 15; i++) begin
            in_data = 32'h100 + 32'(i);
            tick();
        end
        in_valid = 1'b0;
        idle(3);
        @(negedge clk);
        check("wrap_15", 32'(done_cnt), 32'd15);
        tick();
        push_one(32'h8000_0000);
        idle(2);
        @(negedge clk);
        check("wrap_0", 32'(done_cnt), 32'd0);
        check("final_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
